// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard unit: forwarding-select codes,
// mul/div busy-tracker state encoding and counter sizing helper.
// Pure definitions, no logic; imported by the interface-level modules.
package hazard_pkg;

    // Forwarding mux selects for the E-stage ALU operands
    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    // Mul/div occupancy tracker states
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    // Down-counter width for a given mul/div latency (never narrower than 1 bit)
    function automatic int cnt_width(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of pipeline control/address signals seen by the hazard unit.
// master = pipeline datapath side, slave = hazard unit side.
// Purely combinational wiring, no flow control of its own.
interface hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5
);
    // Pipeline status into the hazard unit
    logic                  BranchD;
    logic                  PCSrcD;
    logic                  MemToRegE;
    logic                  RegWriteE;
    logic                  MemToRegM;
    logic                  RegWriteM;
    logic                  RegWriteW;
    logic                  MulDivStartE;
    logic [REG_ADDR_W-1:0] RsD;
    logic [REG_ADDR_W-1:0] RtD;
    logic [REG_ADDR_W-1:0] RsE;
    logic [REG_ADDR_W-1:0] RtE;
    logic [REG_ADDR_W-1:0] WriteRegE;
    logic [REG_ADDR_W-1:0] WriteRegM;
    logic [REG_ADDR_W-1:0] WriteRegW;

    // Hazard unit decisions back to the pipeline
    logic                  StallF;
    logic                  StallD;
    logic                  StallE;
    logic                  FlushD;
    logic                  FlushE;
    logic                  ForwardAD;
    logic                  ForwardBD;
    logic                  MulDivBusy;
    logic [1:0]            ForwardAE;
    logic [1:0]            ForwardBE;

    modport master (
        output BranchD, PCSrcD, MemToRegE, RegWriteE, MemToRegM, RegWriteM,
               RegWriteW, MulDivStartE, RsD, RtD, RsE, RtE,
               WriteRegE, WriteRegM, WriteRegW,
        input  StallF, StallD, StallE, FlushD, FlushE, ForwardAD, ForwardBD,
               MulDivBusy, ForwardAE, ForwardBE
    );

    modport slave (
        input  BranchD, PCSrcD, MemToRegE, RegWriteE, MemToRegM, RegWriteM,
               RegWriteW, MulDivStartE, RsD, RtD, RsE, RtE,
               WriteRegE, WriteRegM, WriteRegW,
        output StallF, StallD, StallE, FlushD, FlushE, ForwardAD, ForwardBD,
               MulDivBusy, ForwardAE, ForwardBE
    );

endinterface

// File: rtl/mdu_busy_ctr.sv
// Tracks a multi-cycle mul/div op sitting in E and raises busy while E must hold.
// Latency: busy is combinational from start in IDLE; op holds E for LAT-1 cycles.
// Backpressure: start is ignored while BUSY; a new op is accepted the cycle BUSY ends.
module mdu_busy_ctr
    import hazard_pkg::*;
#(
    parameter int LAT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy
);

    localparam int              CW     = cnt_width(LAT);
    localparam bit              MULTI  = (LAT >= 2);
    // First BUSY cycle is the second stall cycle, hence LAT-2
    localparam logic [CW-1:0]   RELOAD = MULTI ? CW'(LAT - 2) : '0;

    md_state_t       state;
    md_state_t       state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;

    // State and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state, counter update and busy decode
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (start && MULTI) begin
                    state_nxt = BUSY;
                    cnt_nxt   = RELOAD;
                    busy      = 1'b1;
                end
            end
            BUSY: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CW'(1);
                    busy    = 1'b1;
                end else begin
                    // Release E this cycle; a following op restarts from IDLE next cycle
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding, load-use/branch stalls, mul/div hold.
// Latency: forwarding and stall/flush are combinational; mul/div tracking is registered.
// Backpressure: stalls F/D (and E for mul/div); mul/div tracker only with HAZARD_CTRL_MULDIV_EN.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int MULDIV_LAT = 4
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);

    localparam logic [REG_ADDR_W-1:0] R0 = '0;

    logic lwstall;
    logic branchstall;
    logic mdstall;
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic flush_e;

`ifdef HAZARD_CTRL_MULDIV_EN
    mdu_busy_ctr #(
        .LAT   (MULDIV_LAT)
    ) u_mdu_busy_ctr (
        .clk   (clk),
        .reset (reset),
        .start (hz.MulDivStartE),
        .busy  (mdstall)
    );
`else
    // No mul/div tracking in this build: start and the clock have no consumer
    logic muldiv_unused;
    assign muldiv_unused = hz.MulDivStartE ^ clk ^ (MULDIV_LAT == 0);
    assign mdstall       = 1'b0;
`endif

    // Operand forwarding: M stage has priority over W, register 0 never forwards
    always_comb begin
        hz.ForwardAE = FWD_NONE;
        hz.ForwardBE = FWD_NONE;
        if (hz.RsE != R0 && hz.RsE == hz.WriteRegM && hz.RegWriteM) begin
            hz.ForwardAE = FWD_MEM;
        end else if (hz.RsE != R0 && hz.RsE == hz.WriteRegW && hz.RegWriteW) begin
            hz.ForwardAE = FWD_WB;
        end
        if (hz.RtE != R0 && hz.RtE == hz.WriteRegM && hz.RegWriteM) begin
            hz.ForwardBE = FWD_MEM;
        end else if (hz.RtE != R0 && hz.RtE == hz.WriteRegW && hz.RegWriteW) begin
            hz.ForwardBE = FWD_WB;
        end
        hz.ForwardAD = (hz.RsD != R0) && (hz.RsD == hz.WriteRegM) && hz.RegWriteM;
        hz.ForwardBD = (hz.RtD != R0) && (hz.RtD == hz.WriteRegM) && hz.RegWriteM;
    end

    // Load-use and branch-compare hazards detected in D
    always_comb begin
        lwstall = hz.MemToRegE && (hz.WriteRegE != R0) &&
                  ((hz.RsD == hz.WriteRegE) || (hz.RtD == hz.WriteRegE));
        branchstall = hz.BranchD &&
            ((hz.RegWriteE && (hz.WriteRegE != R0) &&
              ((hz.WriteRegE == hz.RsD) || (hz.WriteRegE == hz.RtD))) ||
             (hz.MemToRegM && (hz.WriteRegM != R0) &&
              ((hz.WriteRegM == hz.RsD) || (hz.WriteRegM == hz.RtD))));
    end

    // Stall/flush priority: mul/div hold freezes F/D/E without bubbles,
    // otherwise a D hazard freezes F/D and bubbles E
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        flush_e = 1'b0;
        if (mdstall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
        end else if (lwstall || branchstall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    // Drive control outputs; everything held quiet while reset is asserted
    always_comb begin
        hz.StallF     = stall_f && !reset;
        hz.StallD     = stall_d && !reset;
        hz.StallE     = stall_e && !reset;
        hz.FlushE     = flush_e && !reset;
        hz.MulDivBusy = mdstall && !reset;
        // A taken branch squashes D only when D is free to advance
        hz.FlushD     = hz.PCSrcD && !stall_d && !reset;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed, table-driven bench for hazard_ctrl plus mul/div sequences.
// Mul/div sequences depend on whether HAZARD_CTRL_MULDIV_EN is defined.
module tb_hazard_ctrl;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;

    hazard_ctrl_if #(.REG_ADDR_W(5)) hz ();

    hazard_ctrl #(
        .REG_ADDR_W (5),
        .MULDIV_LAT (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl = {BranchD,PCSrcD,MemToRegE,RegWriteE,MemToRegM,RegWriteM,RegWriteW,MulDivStartE}
    // exp = {StallF,StallD,StallE, FlushD,FlushE, ForwardAD,ForwardBD, MulDivBusy, ForwardAE, ForwardBE}
    typedef struct {
        string      name;
        logic [7:0] ctl;
        logic [4:0] rsd, rtd, rse, rte, wre, wrm, wrw;
        logic [11:0] exp;
    } vec_t;

    localparam int NV = 18;
    vec_t vt [NV];

    function automatic vec_t mk(input string name, input logic [7:0] ctl,
                                input logic [4:0] rsd, input logic [4:0] rtd,
                                input logic [4:0] rse, input logic [4:0] rte,
                                input logic [4:0] wre, input logic [4:0] wrm,
                                input logic [4:0] wrw, input logic [11:0] exp);
        vec_t v;
        v.name = name; v.ctl = ctl;
        v.rsd = rsd; v.rtd = rtd; v.rse = rse; v.rte = rte;
        v.wre = wre; v.wrm = wrm; v.wrw = wrw; v.exp = exp;
        return v;
    endfunction

    task automatic apply(input logic [7:0] ctl, input logic [4:0] rsd, input logic [4:0] rtd,
                         input logic [4:0] rse, input logic [4:0] rte, input logic [4:0] wre,
                         input logic [4:0] wrm, input logic [4:0] wrw);
        hz.BranchD      = ctl[7];
        hz.PCSrcD       = ctl[6];
        hz.MemToRegE    = ctl[5];
        hz.RegWriteE    = ctl[4];
        hz.MemToRegM    = ctl[3];
        hz.RegWriteM    = ctl[2];
        hz.RegWriteW    = ctl[1];
        hz.MulDivStartE = ctl[0];
        hz.RsD = rsd; hz.RtD = rtd; hz.RsE = rse; hz.RtE = rte;
        hz.WriteRegE = wre; hz.WriteRegM = wrm; hz.WriteRegW = wrw;
    endtask

    function automatic logic [11:0] outs();
        return {hz.StallF, hz.StallD, hz.StallE, hz.FlushD, hz.FlushE,
                hz.ForwardAD, hz.ForwardBD, hz.MulDivBusy, hz.ForwardAE, hz.ForwardBE};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [11:0] exp);
        logic [11:0] act;
        @(negedge clk);
        act = outs();
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    localparam logic [11:0] STALL_LW = 12'b110_01_00_0_00_00;
    localparam logic [11:0] STALL_MD = 12'b111_00_00_1_00_00;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_chk  = 0;
        n_pass = 0;
        reset  = 1'b1;
        apply(8'h00, 0, 0, 0, 0, 0, 0, 0);

        vt[0]  = mk("idle",          8'b0000_0000, 0, 0, 0, 0, 0, 0, 0, 12'b000_00_00_0_00_00);
        vt[1]  = mk("fwd_a_mem_wins",8'b0000_0110, 0, 0, 8, 0, 0, 8, 8, 12'b000_00_00_0_10_00);
        vt[2]  = mk("fwd_r0",        8'b0000_0110, 0, 0, 0, 0, 0, 0, 0, 12'b000_00_00_0_00_00);
        vt[3]  = mk("fwd_wb_both",   8'b0000_0110, 0, 0, 7, 7, 0, 3, 7, 12'b000_00_00_0_01_01);
        vt[4]  = mk("fwd_mixed",     8'b0000_0110, 0, 0, 6, 5, 0, 5, 6, 12'b000_00_00_0_01_10);
        vt[5]  = mk("fwd_no_wr",     8'b0000_0000, 0, 0, 5, 5, 0, 5, 5, 12'b000_00_00_0_00_00);
        vt[6]  = mk("lwstall",       8'b0011_0000, 1, 9, 0, 0, 9, 0, 0, STALL_LW);
        vt[7]  = mk("lw_cleared",    8'b0001_0000, 1, 9, 0, 0, 9, 0, 0, 12'b000_00_00_0_00_00);
        vt[8]  = mk("lw_r0",         8'b0011_0000, 0, 0, 0, 0, 0, 0, 0, 12'b000_00_00_0_00_00);
        vt[9]  = mk("flushd_masked", 8'b0111_0000, 9, 0, 0, 0, 9, 0, 0, STALL_LW);
        vt[10] = mk("flushd",        8'b0100_0000, 0, 0, 0, 0, 0, 0, 0, 12'b000_10_00_0_00_00);
        vt[11] = mk("br_e",          8'b1001_0000, 4, 0, 0, 0, 4, 0, 0, STALL_LW);
        vt[12] = mk("br_m_load",     8'b1000_1100, 4, 0, 0, 0, 0, 4, 0, 12'b110_01_10_0_00_00);
        vt[13] = mk("br_m_alu",      8'b1000_0100, 4, 0, 0, 0, 0, 4, 0, 12'b000_00_10_0_00_00);
        vt[14] = mk("br_fwd_b",      8'b1001_0100, 0, 12,0, 0, 0, 12,0, 12'b000_00_01_0_00_00);
        vt[15] = mk("br_e_rt",       8'b1001_0000, 0, 17,0, 0, 17,0, 0, STALL_LW);
        vt[16] = mk("loadm_nobr",    8'b0000_1100, 4, 0, 0, 0, 0, 4, 0, 12'b000_00_10_0_00_00);
        vt[17] = mk("br_pcsrc",      8'b1101_0000, 4, 0, 0, 0, 4, 0, 0, STALL_LW);

        // Outputs quiet under reset even with hazards and a mul/div start present
        next_cycle();
        apply(8'b0111_0111, 9, 0, 8, 0, 9, 8, 0);
        check("reset_quiet", 12'b000_00_00_0_10_00);
        next_cycle();
        reset = 1'b0;
        apply(8'h00, 0, 0, 0, 0, 0, 0, 0);
        check("after_reset", 12'b000_00_00_0_00_00);

        for (int i = 0; i < NV; i++) begin
            next_cycle();
            apply(vt[i].ctl, vt[i].rsd, vt[i].rtd, vt[i].rse, vt[i].rte,
                  vt[i].wre, vt[i].wrm, vt[i].wrw);
            check(vt[i].name, vt[i].exp);
        end

`ifdef HAZARD_CTRL_MULDIV_EN
        // Two back-to-back ops with start held: 3 stall cycles, one free, repeat
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            if (i == 1) apply(8'b0010_0001, 0, 9, 0, 0, 9, 0, 0);
            else        apply(8'b0000_0001, 0, 0, 0, 0, 0, 0, 0);
            check($sformatf("md_b2b_%0d", i), ((i % 4) != 3) ? STALL_MD : 12'h000);
        end
        next_cycle();
        apply(8'h00, 0, 0, 0, 0, 0, 0, 0);
        check("md_idle_after", 12'h000);

        // Reset in the second BUSY cycle returns to IDLE; a new start then stalls again
        for (int i = 0; i < 7; i++) begin
            next_cycle();
            reset = (i == 2);
            apply(8'b0000_0001, 0, 0, 0, 0, 0, 0, 0);
            check($sformatf("md_rst_%0d", i), (i == 2 || i == 6) ? 12'h000 : STALL_MD);
        end
        next_cycle();
        apply(8'h00, 0, 0, 0, 0, 0, 0, 0);
        check("md_rst_idle", 12'h000);
`else
        // Without mul/div support a start request never stalls
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            apply(8'b0000_0001, 0, 0, 0, 0, 0, 0, 0);
            check($sformatf("md_off_%0d", i), 12'h000);
        end
        next_cycle();
        apply(8'b0010_0001, 0, 9, 0, 0, 9, 0, 0);
        check("md_off_lw", STALL_LW);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameters: REG_ADDR_W, 5, register-number width; MULDIV_LAT, 4, cycles a mul/div occupies E (legal range 1..16).
REQ-002 SHALL have ports: clk in 1, sole clock, all state updates on rising edge; reset in 1, synchronous, active-high.
REQ-003 SHALL have inputs BranchD, PCSrcD, MemToRegE, RegWriteE, MemToRegM, RegWriteM, RegWriteW, MulDivStartE, each 1 bit: decode branch, taken branch in D, E/M/W control bits, mul/div op present in E.
REQ-004 SHALL have inputs RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW, each REG_ADDR_W bits.
REQ-005 SHALL have outputs StallF, StallD, StallE, FlushD, FlushE, ForwardAD, ForwardBD, MulDivBusy (1 bit each) and ForwardAE, ForwardBE (2 bits each).

Function
REQ-006 ForwardAE SHALL be 2'b10 if RsE!=0 && RsE==WriteRegM && RegWriteM; else 2'b01 if RsE!=0 && RsE==WriteRegW && RegWriteW; else 2'b00; ForwardBE identical using RtE.
REQ-007 ForwardAD SHALL be RsD!=0 && RsD==WriteRegM && RegWriteM; ForwardBD identical using RtD; all forwarding outputs combinational, no latency.
REQ-008 lwstall SHALL be MemToRegE && WriteRegE!=0 && (RsD==WriteRegE || RtD==WriteRegE).
REQ-009 branchstall SHALL be BranchD && ((RegWriteE && WriteRegE!=0 && WriteRegE in {RsD,RtD}) || (MemToRegM && WriteRegM!=0 && WriteRegM in {RsD,RtD})).
REQ-010 Mul/div FSM SHALL have states IDLE and BUSY plus down-counter cnt of width clog2(MULDIV_LAT) (min 1).
REQ-011 IDLE with MulDivStartE=1 and MULDIV_LAT>=2: next state BUSY, cnt<=MULDIV_LAT-2.
REQ-012 BUSY with cnt!=0: cnt decrements by 1, stays BUSY; BUSY with cnt==0: next state IDLE; MulDivStartE SHALL be ignored in BUSY.
REQ-013 mdstall SHALL be (IDLE && MulDivStartE && MULDIV_LAT>=2) || (BUSY && cnt!=0), giving exactly MULDIV_LAT-1 stall cycles per op; MULDIV_LAT==1 SHALL never stall.
REQ-014 MulDivBusy SHALL equal mdstall.
REQ-015 Priority: mdstall -> StallF=StallD=StallE=1, FlushE=0, FlushD=0; else lwstall||branchstall -> StallF=StallD=1, StallE=0, FlushE=1; else all stalls and FlushE 0.
REQ-016 FlushD SHALL be PCSrcD && !StallD.
REQ-017 Back-to-back mul/div ops SHALL restart from IDLE on the cycle after BUSY with cnt==0, without an idle bubble.

Reset
REQ-018 reset high at an edge SHALL force state IDLE and cnt 0, including mid-BUSY.
REQ-019 While reset is high StallF, StallD, StallE, FlushD, FlushE, MulDivBusy SHALL be 0; forwarding outputs remain computed per REQ-006/007.

Configuration
REQ-020 Macro HAZARD_CTRL_MULDIV_EN defined: FSM, counter, StallE and mdstall per REQ-010..017.
REQ-021 Macro undefined: no FSM or counter state; StallE=0, MulDivBusy=0, MulDivStartE ignored, MULDIV_LAT unused; all other behaviour unchanged.

Structure
REQ-022 Package hazard_pkg SHALL hold FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10 and the IDLE/BUSY state enum.
REQ-023 FSM plus counter SHALL be a sub-module mdu_busy_ctr (clk, reset, start, busy), instantiated only under HAZARD_CTRL_MULDIV_EN.
REQ-024 Comparisons SHALL use ==/!= only; no X/Z case-equality checks.

Verification
REQ-025 RegWriteM=1, WriteRegM=8, RsE=8, RegWriteW=1, WriteRegW=8 -> ForwardAE=2'b10 (M wins); RsE=0 with WriteRegM=0 -> 2'b00.
REQ-026 MemToRegE=1, WriteRegE=9, RtD=9 -> StallF=StallD=FlushE=1, StallE=0; next cycle MemToRegE=0 -> all 0.
REQ-027 BranchD=1, RegWriteE=1, WriteRegE=4, RsD=4 -> branchstall asserted; then MemToRegM=1, WriteRegM=4 -> stall held; then RegWriteM only -> ForwardAD=1, no stall.
REQ-028 MULDIV_LAT=4, MulDivStartE held 4 cycles -> StallF/D/E=1 for exactly 3 cycles, 4th cycle all 0, FSM IDLE after; second op immediately following -> another 3 stall cycles.
REQ-029 Reset asserted in 2nd BUSY cycle -> next cycle IDLE, all stall/flush 0; PCSrcD=1 with lwstall active -> FlushD=0; without stall -> FlushD=1.
REQ-030 Build without HAZARD_CTRL_MULDIV_EN, MulDivStartE=1 -> StallE=0, MulDivBusy=0; REQ-025..027 still pass.
